// File: rtl/membuf_if.sv
// Data-memory req/gnt/rvalid port: membuf drives the master side, the memory
// answers on the slave side.
interface membuf_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/membuf.sv
// In-order load/store buffer between execute and a req/gnt/rvalid data memory.
// Optional head misalignment drop: define MEMBUF_MISALIGN_CHK_EN.
//
// state  | meaning
// IDLE   | FIFO empty, bus quiet
// REQ    | head op on the bus, waiting for gnt (or dropped if misaligned)
// WAIT   | load granted, waiting for rvalid
module membuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_vld,
  input  logic [8:0]  mem_para,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_full,
  output logic [31:0] mem_pending,
  membuf_if.master    dmem,
  output logic [4:0]  mem_rg_sel,
  output logic [31:0] mem_rg_data,
  output logic        mem_misalign
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [8:0]    fifo_para  [DEPTH];
  logic [31:0]   fifo_addr  [DEPTH];
  logic [31:0]   fifo_wdata [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, head_mis;
  logic [4:0]    h_rd, fl_rd;
  logic [2:0]    h_f3, fl_f3;
  logic          h_st;
  logic [1:0]    h_ofs, fl_ofs;
  logic [31:0]   h_addr, h_wdata, wd_st, ld_data;
  logic [3:0]    be_st;
  logic [7:0]    be_sh, ld_byte;
  logic [15:0]   ld_half;
  logic [AW-1:0] idx;
  logic [31:0]   pend;

  assign mem_full = (count == (AW+1)'(DEPTH));
  assign push     = mem_vld & ~mem_full;
  assign h_rd     = fifo_para[rd_ptr][8:4];
  assign h_f3     = fifo_para[rd_ptr][3:1];
  assign h_st     = fifo_para[rd_ptr][0];
  assign h_addr   = fifo_addr[rd_ptr];
  assign h_wdata  = fifo_wdata[rd_ptr];
  assign h_ofs    = h_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_para[wr_ptr]  <= mem_para;
      fifo_addr[wr_ptr]  <= mem_addr;
      fifo_wdata[wr_ptr] <= mem_wdata;
    end
  end

`ifdef MEMBUF_MISALIGN_CHK_EN
  always_comb begin
    head_mis = 1'b0;
    if (h_f3 == 3'b001 || (!h_st && h_f3 == 3'b101)) head_mis = h_ofs[0];
    else if (h_f3 == 3'b010)                         head_mis = (h_ofs != 2'b00);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_misalign <= 1'b0;
    else      mem_misalign <= (state == S_REQ) && head_mis;
  end
`else
  assign head_mis     = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  // Sub-word store lanes rotate within the word when the offset overruns it.
  always_comb begin
    be_sh = 8'h0F;
    wd_st = h_wdata;
    case (h_f3)
      3'b000: begin
        be_sh = 8'h01 << h_ofs;
        wd_st = {4{h_wdata[7:0]}};
      end
      3'b001: begin
        be_sh = 8'h03 << h_ofs;
        wd_st = {2{h_wdata[15:0]}};
      end
      default: be_sh = 8'h0F;
    endcase
    be_st = be_sh[3:0] | be_sh[7:4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (count != '0 || push) state_nxt = S_REQ;
      S_REQ: begin
        if (pop) begin
          if (!h_st && !head_mis)                   state_nxt = S_WAIT;
          else if (count > (AW+1)'(1) || push)      state_nxt = S_REQ;
          else                                      state_nxt = S_IDLE;
        end
      end
      S_WAIT: if (dmem.rvalid) state_nxt = (count != '0 || push) ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dmem.req   = 1'b0;
    dmem.we    = 1'b0;
    dmem.addr  = '0;
    dmem.be    = '0;
    dmem.wdata = '0;
    pop        = 1'b0;
    if (state == S_REQ) begin
      if (head_mis) begin
        pop = 1'b1;
      end else begin
        dmem.req   = 1'b1;
        dmem.we    = h_st;
        dmem.addr  = {h_addr[31:2], 2'b00};
        dmem.be    = h_st ? be_st : 4'b1111;
        dmem.wdata = h_st ? wd_st : '0;
        pop        = dmem.gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_rd  <= '0;
      fl_f3  <= '0;
      fl_ofs <= '0;
    end else if (state == S_REQ && pop && !h_st && !head_mis) begin
      fl_rd  <= h_rd;
      fl_f3  <= h_f3;
      fl_ofs <= h_ofs;
    end
  end

  always_comb begin
    case (fl_ofs)
      2'd0:    ld_byte = dmem.rdata[7:0];
      2'd1:    ld_byte = dmem.rdata[15:8];
      2'd2:    ld_byte = dmem.rdata[23:16];
      default: ld_byte = dmem.rdata[31:24];
    endcase
    ld_half = fl_ofs[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (fl_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem.rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rg_sel  <= '0;
      mem_rg_data <= '0;
    end else if (state == S_WAIT && dmem.rvalid) begin
      mem_rg_sel  <= fl_rd;
      mem_rg_data <= ld_data;
    end else begin
      mem_rg_sel  <= '0;
    end
  end

  always_comb begin
    pend = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((AW+1)'(i) < count && !fifo_para[idx][0]) pend[fifo_para[idx][8:4]] = 1'b1;
    end
    if (state == S_WAIT) pend[fl_rd] = 1'b1;
    pend[0] = 1'b0;
  end

  assign mem_pending = pend;
endmodule

// File: tb/tb_membuf.sv
// Directed bench for membuf: lanes, load extension, full/backpressure,
// misalignment handling and reset during a pending load.
module tb_membuf;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_vld = 1'b0;
  logic [8:0]  mem_para = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_full;
  logic [31:0] mem_pending;
  logic [4:0]  mem_rg_sel;
  logic [31:0] mem_rg_data;
  logic        mem_misalign;
  int          total = 0;
  int          bad = 0;

  membuf_if bus ();

  membuf #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_vld      (mem_vld),
    .mem_para     (mem_para),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_full     (mem_full),
    .mem_pending  (mem_pending),
    .dmem         (bus.master),
    .mem_rg_sel   (mem_rg_sel),
    .mem_rg_data  (mem_rg_data),
    .mem_misalign (mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic [2:0] f3, input logic st,
                       input logic [31:0] a, input logic [31:0] d);
    mem_vld   = 1'b1;
    mem_para  = {rd, f3, st};
    mem_addr  = a;
    mem_wdata = d;
  endtask

  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] word, input logic [31:0] exp);
    drive(rd, f3, 1'b0, a, 32'h0);
    tick();
    mem_vld = 1'b0;
    chk({tag, ".req"}, bus.req, 32'h1);
    chk({tag, ".be"}, bus.be, 32'hF);
    chk({tag, ".pend"}, mem_pending, (rd != 5'd0) ? (32'h1 << rd) : 32'h0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    chk({tag, ".wait_req"}, bus.req, 32'h0);
    bus.rvalid = 1'b1;
    bus.rdata  = word;
    tick();
    bus.rvalid = 1'b0;
    chk({tag, ".sel"}, mem_rg_sel, rd);
    if (rd != 5'd0) chk({tag, ".data"}, mem_rg_data, exp);
    chk({tag, ".pend_clr"}, mem_pending, 32'h0);
    tick();
    chk({tag, ".sel_off"}, mem_rg_sel, 32'h0);
  endtask

  initial begin
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;
    #2;
    chk("rst.full", mem_full, 32'h0);
    chk("rst.pend", mem_pending, 32'h0);
    chk("rst.req", bus.req, 32'h0);
    chk("rst.we", bus.we, 32'h0);
    chk("rst.addr", bus.addr, 32'h0);
    chk("rst.be", bus.be, 32'h0);
    chk("rst.wdata", bus.wdata, 32'h0);
    chk("rst.sel", mem_rg_sel, 32'h0);
    chk("rst.data", mem_rg_data, 32'h0);
    chk("rst.mis", mem_misalign, 32'h0);
    tick();
    tick();
    rst = 1'b1;

    // SW 0x11223344 @0x100
    drive(5'd0, 3'b010, 1'b1, 32'h100, 32'h1122_3344);
    tick();
    mem_vld = 1'b0;
    chk("sw.req", bus.req, 32'h1);
    chk("sw.we", bus.we, 32'h1);
    chk("sw.be", bus.be, 32'hF);
    chk("sw.addr", bus.addr, 32'h100);
    chk("sw.wdata", bus.wdata, 32'h1122_3344);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    chk("sw.done", bus.req, 32'h0);

    do_load("lw", 5'd5, 3'b010, 32'h100, 32'h1122_3344, 32'h1122_3344);
    do_load("lb", 5'd7, 3'b000, 32'h103, 32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load("lbu", 5'd7, 3'b100, 32'h103, 32'h80FF_FFFF, 32'h0000_0080);
    do_load("lh", 5'd9, 3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", 5'd9, 3'b101, 32'h102, 32'h8001_0000, 32'h0000_8001);
    do_load("lbu1", 5'd12, 3'b100, 32'h101, 32'h0000_C300, 32'h0000_00C3);
    do_load("lw_x0", 5'd0, 3'b010, 32'h104, 32'hAAAA_5555, 32'h0);

    // SB 0xAB @0x201
    drive(5'd0, 3'b000, 1'b1, 32'h201, 32'h0000_00AB);
    tick();
    mem_vld = 1'b0;
    chk("sb.be", bus.be, 32'h2);
    chk("sb.wdata", bus.wdata, 32'hABAB_ABAB);
    chk("sb.addr", bus.addr, 32'h200);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;

    // SH 0x1234 @0x202
    drive(5'd0, 3'b001, 1'b1, 32'h202, 32'h0000_1234);
    tick();
    mem_vld = 1'b0;
    chk("sh.be", bus.be, 32'hC);
    chk("sh.wdata", bus.wdata, 32'h1234_1234);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;

    // Fill the FIFO with gnt held low
    drive(5'd0, 3'b010, 1'b1, 32'h300, 32'h1);
    tick();
    drive(5'd10, 3'b010, 1'b0, 32'h304, 32'h0);
    tick();
    drive(5'd0, 3'b010, 1'b1, 32'h308, 32'h3);
    tick();
    drive(5'd11, 3'b010, 1'b0, 32'h30C, 32'h0);
    tick();
    chk("full.set", mem_full, 32'h1);
    chk("full.pend", mem_pending, 32'h0000_0C00);
    chk("full.addr", bus.addr, 32'h300);
    drive(5'd0, 3'b010, 1'b1, 32'h400, 32'h5);
    tick();
    chk("full.hold", mem_full, 32'h1);
    chk("full.stable_addr", bus.addr, 32'h300);
    chk("full.stable_we", bus.we, 32'h1);
    chk("full.stable_wd", bus.wdata, 32'h1);
    bus.gnt = 1'b1;
    tick();
    chk("full.drop", mem_full, 32'h0);
    chk("full.head2", bus.addr, 32'h304);
    chk("full.head2_we", bus.we, 32'h0);
    tick();
    mem_vld = 1'b0;
    bus.gnt = 1'b0;
    chk("full.wait_req", bus.req, 32'h0);
    chk("full.wait_pend", mem_pending, 32'h0000_0C00);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hCAFE_F00D;
    tick();
    bus.rvalid = 1'b0;
    chk("full.wb1_sel", mem_rg_sel, 32'd10);
    chk("full.wb1_data", mem_rg_data, 32'hCAFE_F00D);
    chk("full.wb1_pend", mem_pending, 32'h0000_0800);
    chk("full.head3", bus.addr, 32'h308);
    chk("full.head3_we", bus.we, 32'h1);
    bus.gnt = 1'b1;
    tick();
    chk("full.head4", bus.addr, 32'h30C);
    chk("full.head4_we", bus.we, 32'h0);
    tick();
    bus.gnt = 1'b0;
    chk("full.wait2_req", bus.req, 32'h0);
    chk("full.wait2_sel", mem_rg_sel, 32'h0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h1234_5678;
    tick();
    bus.rvalid = 1'b0;
    chk("full.wb2_sel", mem_rg_sel, 32'd11);
    chk("full.wb2_data", mem_rg_data, 32'h1234_5678);
    chk("full.head5", bus.addr, 32'h400);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    chk("full.end_req", bus.req, 32'h0);
    chk("full.end_pend", mem_pending, 32'h0);

    // Misaligned LW @0x102 rd=3
    drive(5'd3, 3'b010, 1'b0, 32'h102, 32'h0);
    tick();
    mem_vld = 1'b0;
`ifdef MEMBUF_MISALIGN_CHK_EN
    chk("mis.req", bus.req, 32'h0);
    chk("mis.pend", mem_pending, 32'h8);
    tick();
    chk("mis.pulse", mem_misalign, 32'h1);
    chk("mis.pend_clr", mem_pending, 32'h0);
    chk("mis.no_req", bus.req, 32'h0);
    chk("mis.no_wb", mem_rg_sel, 32'h0);
    tick();
    chk("mis.pulse_end", mem_misalign, 32'h0);
`else
    chk("mis.req", bus.req, 32'h1);
    chk("mis.be", bus.be, 32'hF);
    chk("mis.addr", bus.addr, 32'h100);
    chk("mis.flag", mem_misalign, 32'h0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h5566_7788;
    tick();
    bus.rvalid = 1'b0;
    chk("mis.sel", mem_rg_sel, 32'd3);
    chk("mis.data", mem_rg_data, 32'h5566_7788);
    tick();
`endif

    // Reset during WAIT with two entries queued
    drive(5'd4, 3'b010, 1'b0, 32'h500, 32'h0);
    tick();
    drive(5'd0, 3'b010, 1'b1, 32'h504, 32'h9);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    drive(5'd6, 3'b010, 1'b0, 32'h508, 32'h0);
    tick();
    mem_vld = 1'b0;
    chk("rw.pend", mem_pending, 32'h0000_0050);
    chk("rw.req", bus.req, 32'h0);
    rst = 1'b0;
    #1;
    chk("rw.async_pend", mem_pending, 32'h0);
    chk("rw.async_full", mem_full, 32'h0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD_BEEF;
    tick();
    chk("rw.in_rst_sel", mem_rg_sel, 32'h0);
    rst = 1'b1;
    tick();
    bus.rvalid = 1'b0;
    chk("rw.late_sel", mem_rg_sel, 32'h0);
    chk("rw.late_data", mem_rg_data, 32'h0);
    chk("rw.req", bus.req, 32'h0);
    chk("rw.addr", bus.addr, 32'h0);
    chk("rw.be", bus.be, 32'h0);
    chk("rw.pend_end", mem_pending, 32'h0);
    chk("rw.mis", mem_misalign, 32'h0);
    tick();
    chk("rw.empty", bus.req, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
